hack_memory_mmio: RTL and testbench

Parametrised successor to the data-memory subsystem of the Hack computer. It sits between `hack_cpu` (`outM`/`writeM`/`addressM` → `in`/`load`/`address`; `out` → `inM`) and the platform. It implements data RAM, a screen buffer with a second display read port, a buffered keyboard queue with a valid/ready handshake, and a free-running cycle timer. Every region is memory-mapped, and all region sizes are parameters.

---
 rtl/hack_pkg.sv | 16 +
 rtl/hack_kbd_fifo.sv | 71 +++++++
 rtl/hack_memory_mmio.sv | 135 +++++++++++++
 tb/tb_hack_memory_mmio.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared address-map defaults and STAT register layout for the Hack data-memory subsystem.
package hack_pkg;

    localparam int RAM_DEPTH    = 16384;
    localparam int SCREEN_BASE  = 16384;
    localparam int SCREEN_DEPTH = 8192;
    localparam int KBD_ADDR     = 24576;
    localparam int STAT_ADDR    = 24577;
    localparam int TIMER_ADDR   = 24578;

    localparam int STAT_NOT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_COUNT_LSB     = 2;
    localparam int STAT_COUNT_W       = 6;

endpackage

// File: rtl/hack_kbd_fifo.sv
// Keyboard code queue: power-of-2 circular buffer; head reads 0 while empty.
module hack_kbd_fifo #(
    parameter  int DATA_W    = 16,
    parameter  int KBD_DEPTH = 4,
    localparam int PTR_W     = $clog2(KBD_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [KBD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == CNT_W'(KBD_DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    // A full queue refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Queue storage; contents need no reset since head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head word, forced to zero when nothing is queued.
    always_comb begin
        head = {DATA_W{1'b0}};
        if (empty) begin
            head = {DATA_W{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/hack_memory_mmio.sv
// Hack data-memory subsystem: RAM, dual-read screen buffer, keyboard FIFO and cycle timer,
// all memory-mapped behind a combinational CPU read port.
module hack_memory_mmio #(
    parameter  int DATA_W       = 16,
    parameter  int ADDR_W       = 15,
    parameter  int RAM_DEPTH    = hack_pkg::RAM_DEPTH,
    parameter  int SCREEN_BASE  = hack_pkg::SCREEN_BASE,
    parameter  int SCREEN_DEPTH = hack_pkg::SCREEN_DEPTH,
    parameter  int KBD_ADDR     = hack_pkg::KBD_ADDR,
    parameter  int STAT_ADDR    = hack_pkg::STAT_ADDR,
    parameter  int TIMER_ADDR   = hack_pkg::TIMER_ADDR,
    parameter  int KBD_DEPTH    = 4,
    localparam int SCR_AW       = $clog2(SCREEN_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_code,
    output logic              key_ready,
    input  logic [SCR_AW-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_data
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int KBD_CW = $clog2(KBD_DEPTH) + 1;

    logic [DATA_W-1:0] ram_mem_r [RAM_DEPTH];
    logic [DATA_W-1:0] scr_mem_r [SCREEN_DEPTH];
    logic [DATA_W-1:0] timer_r;
    logic [DATA_W-1:0] scr_data_r;

    logic [31:0]       addr_ext_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [SCR_AW-1:0] scr_off_s;
    logic              in_ram_s;
    logic              in_scr_s;
    logic              is_kbd_s;
    logic              is_stat_s;
    logic              is_timer_s;

    logic [DATA_W-1:0] kbd_head_s;
    logic [KBD_CW-1:0] kbd_count_s;
    logic              kbd_full_s;
    logic              kbd_empty_s;
    logic [DATA_W-1:0] stat_s;

    assign addr_ext_s = {{(32-ADDR_W){1'b0}}, address};
    assign ram_idx_s  = addr_ext_s[RAM_AW-1:0];
    assign scr_off_s  = SCR_AW'(addr_ext_s - 32'(SCREEN_BASE));
    assign in_ram_s   = (addr_ext_s < 32'(RAM_DEPTH));
    assign in_scr_s   = (addr_ext_s >= 32'(SCREEN_BASE)) &&
                        (addr_ext_s <  32'(SCREEN_BASE + SCREEN_DEPTH));
    assign is_kbd_s   = (addr_ext_s == 32'(KBD_ADDR));
    assign is_stat_s  = (addr_ext_s == 32'(STAT_ADDR));
    assign is_timer_s = (addr_ext_s == 32'(TIMER_ADDR));

    assign key_ready  = ~kbd_full_s;
    assign scr_data   = scr_data_r;

    hack_kbd_fifo #(
        .DATA_W    (DATA_W),
        .KBD_DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (key_valid),
        .push_data (key_code),
        .pop       (load & is_kbd_s),
        .head      (kbd_head_s),
        .count     (kbd_count_s),
        .full      (kbd_full_s),
        .empty     (kbd_empty_s)
    );

    // CPU writes into RAM and screen; arrays are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (load && in_ram_s) begin
            ram_mem_r[ram_idx_s] <= in;
        end
        if (load && in_scr_s) begin
            scr_mem_r[scr_off_s] <= in;
        end
    end

    // Display port: non-blocking read of the pre-write word gives read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scr_data_r <= {DATA_W{1'b0}};
        end else begin
            scr_data_r <= scr_mem_r[scr_addr];
        end
    end

    // Free-running timer; a CPU write wins over the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= {DATA_W{1'b0}};
        end else if (load && is_timer_s) begin
            timer_r <= in;
        end else begin
            timer_r <= timer_r + DATA_W'(1);
        end
    end

    // STAT word assembly.
    always_comb begin
        stat_s = {DATA_W{1'b0}};
        stat_s[hack_pkg::STAT_NOT_EMPTY_BIT] = ~kbd_empty_s;
        stat_s[hack_pkg::STAT_FULL_BIT]      = kbd_full_s;
        stat_s[hack_pkg::STAT_COUNT_LSB +: KBD_CW] = kbd_count_s;
    end

    // CPU read mux; unmapped addresses read 0.
    always_comb begin
        out = {DATA_W{1'b0}};
        if (in_ram_s) begin
            out = ram_mem_r[ram_idx_s];
        end else if (in_scr_s) begin
            out = scr_mem_r[scr_off_s];
        end else if (is_kbd_s) begin
            out = kbd_head_s;
        end else if (is_stat_s) begin
            out = stat_s;
        end else if (is_timer_s) begin
            out = timer_r;
        end else begin
            out = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_hack_memory_mmio.sv
// Directed self-checking bench for hack_memory_mmio with hand-computed expectations.
module tb_hack_memory_mmio;

    localparam int KBD   = hack_pkg::KBD_ADDR;
    localparam int STAT  = hack_pkg::STAT_ADDR;
    localparam int TIMER = hack_pkg::TIMER_ADDR;
    localparam int SCR   = hack_pkg::SCREEN_BASE;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        load;
    logic [14:0] address;
    logic [15:0] dout;
    logic        key_valid;
    logic [15:0] key_code;
    logic        key_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;

    int vectors = 0;
    int errors  = 0;

    hack_memory_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .load      (load),
        .address   (address),
        .out       (dout),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        address = 15'(a);
        din     = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [15:0] expv);
        address = 15'(a);
        #1;
        check(tag, dout, expv);
    endtask

    task automatic push(input logic [15:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; din = 16'h0000; load = 1'b0; address = 15'd0;
        key_valid = 1'b0; key_code = 16'h0000; scr_addr = 13'd0;

        // Reset state
        tick();
        tick();
        rd("rst_stat", STAT, 16'h0000);
        rd("rst_kbd", KBD, 16'h0000);
        rd("rst_timer", TIMER, 16'h0000);
        check("rst_key_ready", {15'd0, key_ready}, 16'h0001);
        check("rst_scr_data", scr_data, 16'h0000);
        reset = 1'b1;
        rd("timer0", TIMER, 16'h0000);
        tick();
        check("timer1", dout, 16'h0001);
        tick();
        check("timer2", dout, 16'h0002);

        // RAM and screen
        wr(5, 16'hBEEF);
        wr(SCR + 3, 16'h1234);
        rd("ram5", 5, 16'hBEEF);
        scr_addr = 13'd3;
        tick();
        check("scr_port", scr_data, 16'h1234);
        wr(SCR + 3, 16'h5678);
        check("scr_rbw_old", scr_data, 16'h1234);
        tick();
        check("scr_rbw_new", scr_data, 16'h5678);
        rd("scr_cpu", SCR + 3, 16'h5678);
        wr(30000, 16'hFFFF);
        rd("unmapped", 30000, 16'h0000);
        rd("ram5_after", 5, 16'hBEEF);
        wr(STAT, 16'hFFFF);
        rd("stat_ro", STAT, 16'h0000);

        // FIFO fill
        push(16'h0041);
        rd("kbd_first", KBD, 16'h0041);
        push(16'h0042);
        push(16'h0043);
        check("ready_3", {15'd0, key_ready}, 16'h0001);
        push(16'h0044);
        check("ready_full", {15'd0, key_ready}, 16'h0000);
        rd("stat_full", STAT, 16'h0013);
        rd("kbd_head", KBD, 16'h0041);
        // Pop while full with a key offered: the offer must be refused
        key_valid = 1'b1;
        key_code  = 16'h0055;
        wr(KBD, 16'h9999);
        key_valid = 1'b0;
        rd("stat_pop_full", STAT, 16'h000D);
        rd("kbd_42", KBD, 16'h0042);
        wr(KBD, 16'h0000);
        rd("kbd_43", KBD, 16'h0043);
        wr(KBD, 16'h0000);
        rd("kbd_44", KBD, 16'h0044);
        wr(KBD, 16'h0000);
        rd("kbd_empty", KBD, 16'h0000);
        rd("stat_empty", STAT, 16'h0000);
        wr(KBD, 16'h0000);
        rd("stat_underflow", STAT, 16'h0000);
        rd("kbd_underflow", KBD, 16'h0000);

        // Simultaneous push and pop at two entries
        push(16'h0046);
        push(16'h0047);
        rd("stat_two", STAT, 16'h0009);
        key_valid = 1'b1;
        key_code  = 16'h0045;
        wr(KBD, 16'h0000);
        key_valid = 1'b0;
        rd("stat_pushpop", STAT, 16'h0009);
        rd("kbd_pushpop", KBD, 16'h0047);
        wr(KBD, 16'h0000);
        rd("kbd_45", KBD, 16'h0045);
        wr(KBD, 16'h0000);
        rd("stat_drained", STAT, 16'h0000);

        // Timer load and wrap
        wr(TIMER, 16'hFFFE);
        rd("timer_load", TIMER, 16'hFFFE);
        tick();
        check("timer_ffff", dout, 16'hFFFF);
        tick();
        check("timer_wrap", dout, 16'h0000);

        // Reset with keys queued and a handshake pending
        wr(7, 16'hCAFE);
        push(16'h0061);
        push(16'h0062);
        push(16'h0063);
        rd("stat_three", STAT, 16'h000D);
        key_valid = 1'b1;
        key_code  = 16'h0070;
        reset     = 1'b0;
        #1;
        check("mid_rst_stat", dout, 16'h0000);
        check("mid_rst_ready", {15'd0, key_ready}, 16'h0001);
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_stat", dout, 16'h0000);
        tick();
        key_valid = 1'b0;
        rd("post_rst_push", STAT, 16'h0005);
        rd("post_rst_kbd", KBD, 16'h0070);
        rd("ram_kept", 7, 16'hCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
